// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StSub,
    StSubAck,
    StWdat,
    StWdatAck,
    StRdat,
    StRdatAck,
    StIgnore
  } i2c_state_e;

  localparam logic [7:0] I2cAddrWrDefault = 8'h72;
  localparam logic       I2cAck           = 1'b0;
  localparam logic       I2cNack          = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-sample agreement glitch filter.
module i2c_in_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic din_i,
  output logic dout_o
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]      sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], din_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // cnt_q holds how many consecutive differing samples preceded this one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FILT_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dout_o = filt_q;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a 256-byte register file with an auto-incrementing pointer.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = I2cAddrWrDefault[7:1],
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       WR_VALID,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic [7:0] HOST_RADDR,
  output logic [7:0] HOST_RDATA,
  output logic       BUSY
);

  logic scl_f, sda_f;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] regfile_q [256];
  logic [7:0] rd_byte, rx_byte;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .din_i  (I2C_SCLK),
    .dout_o (scl_f)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .din_i  (I2C_SDAT),
    .dout_o (sda_f)
  );

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign rd_byte   = regfile_q[ptr_q];
  assign rx_byte   = {shift_q[6:0], sda_f};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file is deliberately outside the reset domain.
  always_ff @(posedge iCLK) begin
    if (iRST_N && wr_valid_d) begin
      regfile_q[wr_addr_d] <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StAddr, StSub, StWdat: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == StWdat && bit_cnt_q == 4'd7) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                rw_d    = shift_q[0];
              end else begin
                state_d  = StIgnore;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == StSub) begin
              ptr_d   = shift_q;
              state_d = StSubAck;
            end else begin
              state_d = StWdatAck;
            end
          end
        end
        StAddrAck, StSubAck, StWdatAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (state_q == StAddrAck && rw_q) begin
              state_d  = StRdat;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = (state_q == StAddrAck) ? StSub : StWdat;
              sda_oe_d = 1'b0;
            end
            if (state_q == StWdatAck) begin
              ptr_d = ptr_q + 8'd1;
            end
          end
        end
        StRdat: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = StRdatAck;
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 8'd1;
              bit_cnt_d = '0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdatAck: begin
          // Master's ACK bit is parked in shift_q[0] until the falling edge.
          if (scl_rise) begin
            shift_d[0] = sda_f;
          end else if (scl_fall) begin
            if (shift_q[0] == I2cAck) begin
              state_d  = StRdat;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    WR_VALID   = wr_valid_q;
    WR_ADDR    = wr_addr_q;
    WR_DATA    = wr_data_q;
    BUSY       = busy_q;
    HOST_RDATA = regfile_q[HOST_RADDR];
  end

  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Randomised bus-level bench for i2c_reg_target against a byte-array register model.
module tb_i2c_reg_target;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_w;
  logic       wr_valid, busy;
  logic [7:0] wr_addr, wr_data, host_rdata;
  logic [7:0] host_raddr = 8'h00;

  always #5 clk = ~clk;

  pullup (sda_w);
  assign sda_w = m_sda ? 1'bz : 1'b0;

  i2c_reg_target #(.DEV_ADDR(7'h39), .FILT_LEN(3)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .I2C_SCLK   (m_scl),
    .I2C_SDAT   (sda_w),
    .WR_VALID   (wr_valid),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .HOST_RADDR (host_raddr),
    .HOST_RDATA (host_rdata),
    .BUSY       (busy)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  mem [256];
  logic [7:0]  mptr = 8'h00;
  logic [15:0] exp_wq [$];
  logic [7:0]  txq [$];
  logic [15:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Every committed write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      if (exp_wq.size() == 0) begin
        check("wr_unexpected", {wr_addr, wr_data}, 16'hxxxx);
      end else begin
        mon_e = exp_wq.pop_front();
        check("wr_addr", wr_addr, mon_e[15:8]);
        check("wr_data", wr_data, mon_e[7:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(Q / 2);
    s = sda_w; tick(Q / 2);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      if (i == glitch_bit) begin
        m_sda = b[i]; tick(Q / 2);
        m_scl = 1'b1; tick(1);
        m_scl = 1'b0; tick(Q / 2);
      end
      clk_bit(b[i], s);
    end
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
    m_sda = 1'b1;
  endtask

  task automatic check_mem(input logic [7:0] a);
    host_raddr = a;
    #1;
    check("regfile", host_rdata, mem[a]);
  endtask

  task automatic wr_txn(input logic [7:0] sub, input int glitch_byte);
    logic a;
    bus_start();
    check("busy_start", busy, 1'b1);
    write_byte(8'h72, -1, a); check("ack_addr_w", a, 1'b0);
    write_byte(sub, -1, a);   check("ack_sub", a, 1'b0);
    mptr = sub;
    foreach (txq[i]) begin
      exp_wq.push_back({mptr, txq[i]});
      mem[mptr] = txq[i];
      mptr++;
      write_byte(txq[i], (i == glitch_byte) ? 3 : -1, a);
      check("ack_data", a, 1'b0);
    end
    bus_stop();
    check("busy_stop", busy, 1'b0);
    check("wr_pending", exp_wq.size(), 0);
  endtask

  task automatic rd_txn(input logic [7:0] sub, input int n);
    logic       a;
    logic [7:0] d;
    bus_start();
    write_byte(8'h72, -1, a); check("ack_addr_w", a, 1'b0);
    write_byte(sub, -1, a);   check("ack_sub", a, 1'b0);
    mptr = sub;
    bus_start();
    write_byte(8'h73, -1, a); check("ack_addr_r", a, 1'b0);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      check("rd_data", d, mem[mptr]);
      mptr++;
    end
    check("sda_released", sda_w, 1'b1);
    bus_stop();
    check("busy_stop", busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] s;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    tick(5);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_sda", sda_w, 1'b1);
    rst_n = 1'b1;
    tick(Q);

    // Directed: single write, wrap-around write, read back after repeated START.
    txq = '{8'h03};
    wr_txn(8'h98, -1);
    check_mem(8'h98);
    txq = '{8'h11, 8'h22, 8'h33};
    wr_txn(8'hFE, -1);
    check_mem(8'hFE); check_mem(8'hFF); check_mem(8'h00);
    rd_txn(8'h98, 2);

    // Foreign address: never ACKed, nothing committed, BUSY held until STOP.
    bus_start();
    write_byte(8'h70, -1, a); check("nack_foreign", a, 1'b1);
    for (int k = 0; k < 4; k++) begin
      write_byte(8'($urandom), -1, a);
      check("nack_foreign_data", a, 1'b1);
      check("busy_foreign", busy, 1'b1);
    end
    bus_stop();
    check("busy_foreign_stop", busy, 1'b0);

    // Single-cycle SCL glitch inside a data byte must not shift a bit.
    txq = '{8'h5A, 8'hC3};
    wr_txn(8'h40, 0);
    check_mem(8'h40); check_mem(8'h41);

    // Reset during bit 4 of a written byte; later bits must be ignored.
    bus_start();
    write_byte(8'h72, -1, a);
    write_byte(8'h50, -1, a);
    s = 8'hB5;
    for (int i = 7; i >= 5; i--) clk_bit(s[i], a);
    m_sda = s[4]; tick(Q);
    m_scl = 1'b1; tick(Q / 2);
    rst_n = 1'b0;
    #1;
    check("rst_busy_mid", busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    mptr = 8'h00;
    tick(Q / 2);
    m_scl = 1'b0; tick(Q);
    for (int i = 3; i >= 0; i--) clk_bit(s[i], a);
    clk_bit(1'b1, a);
    check("no_ack_after_rst", a, 1'b1);
    bus_stop();
    check_mem(8'h50);

    // Reset while the target drives a 0 data bit: SDA released immediately.
    txq = '{8'h00};
    wr_txn(8'h60, -1);
    bus_start();
    write_byte(8'h72, -1, a);
    write_byte(8'h60, -1, a);
    bus_start();
    write_byte(8'h73, -1, a);
    for (int i = 7; i >= 5; i--) clk_bit(1'b1, a);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q / 2);
    check("sda_driven_low", sda_w, 1'b0);
    rst_n = 1'b0;
    #1;
    check("sda_rst_release", sda_w, 1'b1);
    tick(2);
    rst_n = 1'b1;
    mptr = 8'h00;
    tick(Q / 2);
    m_scl = 1'b0; tick(Q);
    bus_stop();

    // Randomised write / read-back transactions.
    for (int t = 0; t < 5; t++) begin
      int n;
      s = 8'($urandom);
      n = int'($urandom_range(1, 4));
      txq.delete();
      for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
      wr_txn(s, -1);
      rd_txn(s + 8'(t), int'($urandom_range(1, 3)));
      check_mem(8'($urandom));
      check_mem(s);
    end

    tick(Q);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_reg_target.md
I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, the 7-bit I2C target address (8'h72 write / 8'h73 read).
REQ-002 SHALL have parameter FILT_LEN, default 3, the number of consecutive equal samples needed to accept a SCL/SDA level change.
REQ-003 SHALL have port iCLK, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-004 SHALL have port iRST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port I2C_SCLK, input, 1 bit: I2C clock from the bus master, asynchronous to iCLK.
REQ-006 SHALL have port I2C_SDAT, inout, 1 bit: I2C data, open-drain; this block drives only 1'b0 or 1'bz.
REQ-007 SHALL have port WR_VALID, output, 1 bit: one-iCLK pulse when a written byte is committed.
REQ-008 SHALL have port WR_ADDR, output, 8 bits: register index of the committed byte.
REQ-009 SHALL have port WR_DATA, output, 8 bits: value of the committed byte.
REQ-010 SHALL have port HOST_RADDR, input, 8 bits: host-side read index into the register file.
REQ-011 SHALL have port HOST_RDATA, output, 8 bits: register-file content at HOST_RADDR, combinational.
REQ-012 SHALL have port BUSY, output, 1 bit: high from an accepted START up to the next STOP.

Function
REQ-013 SHALL synchronise I2C_SCLK and I2C_SDAT through 2 flops, then filter them with FILT_LEN-sample agreement; edge detection uses the filtered signals only.
REQ-014 SHALL detect START (and repeated START) as filtered SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL sample data bits on the filtered SCL rising edge, MSB first, and change its own SDA drive only on the SCL falling edge.
REQ-016 SHALL implement these states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE.
REQ-017 SHALL go to ADDR from any state on START, releasing SDA within 1 iCLK.
REQ-018 SHALL go to IDLE from any state on STOP, releasing SDA within 1 iCLK.
REQ-019 SHALL, in ADDR, compare bits[7:1] of the received byte with DEV_ADDR after the 8th bit; on a match it goes to ADDR_ACK, otherwise to IGNORE (no ACK is driven).
REQ-020 SHALL hold SDA low during ACK from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
REQ-021 SHALL, after the address ACK, go to SUB if R/W=0 and to RDAT if R/W=1.
REQ-022 SHALL, in SUB, load the received byte into the 8-bit pointer and ACK it; every following byte in the same transaction goes through WDAT.
REQ-023 SHALL, in WDAT, write the byte to regfile[pointer], pulse WR_VALID with WR_ADDR=pointer and WR_DATA=byte at the 8th SCL rising edge, ACK, then increment the pointer.
REQ-024 SHALL, in RDAT, load regfile[pointer] into the shift register at the SCL falling edge that ends the preceding ACK, drive each bit as 0 or z, then increment the pointer after bit 8.
REQ-025 SHALL, in RDAT_ACK, release SDA and sample the master's ACK: ACK (0) returns to RDAT, NACK (1) goes to IGNORE.
REQ-026 SHALL wrap the pointer from 8'hFF to 8'h00, both on write and on read.
REQ-027 SHALL keep the pointer across repeated START and STOP, so that a write of SUB followed by a repeated START and read returns regfile[SUB].
REQ-028 SHALL give a host read and a bus write to the same index in the same cycle the old value on HOST_RDATA; the new value appears the next cycle.
REQ-029 SHALL, in IGNORE, never drive SDA; it waits for START or STOP.

Reset
REQ-030 SHALL, while iRST_N is low, go to IDLE, release SDA (z), and clear WR_VALID, WR_ADDR, WR_DATA, BUSY, the pointer, the bit counter and the filters (to 1).
REQ-031 SHALL leave regfile contents unchanged by reset; simulation initial value is 8'h00.
REQ-032 SHALL, after reset is released mid-transaction, ignore the bus until the next START.

Structure
REQ-033 SHALL place the state enumeration, the 8'h72 default address constant and the ACK/NACK constants in shared package i2c_pkg.
REQ-034 SHALL put the synchroniser and glitch filter in sub-module i2c_in_filter, instantiated once per line.

Verification
REQ-035 SHALL cover: write 72,98,03 -> three ACKs; regfile[98]=03; one WR_VALID with WR_ADDR=98 and WR_DATA=03.
REQ-036 SHALL cover: write 72,FE,11,22,33 -> regfile[FE]=11, [FF]=22, [00]=33 (wrap); three WR_VALID pulses.
REQ-037 SHALL cover: write 72,98, repeated START, 73, read 2 bytes with ACK then NACK -> returns 03 then regfile[99]; SDA released before STOP.
REQ-038 SHALL cover: address 70 followed by 4 bytes -> no ACK at any bit 9, no WR_VALID, BUSY high until STOP.
REQ-039 SHALL cover: iRST_N pulsed low during bit 4 of a data byte -> SDA z at once; that byte is not committed; the next full transaction works.
REQ-040 SHALL cover: a 1-iCLK glitch on SCL while FILT_LEN=3 -> no bit shifted and no state change.
